// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM state encoding and port ids.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic PORT_IF   = 1'b0;
    localparam logic PORT_DATA = 1'b1;

endpackage

// File: rtl/riscv_arb_fair_sel.sv
// Data-first winner selection with a bounded run of data grants while fetch waits.
module riscv_arb_fair_sel
    import riscv_pkg::*;
#(
    parameter int MAX_CONSEC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic p0_req,
    input  logic p1_req,
    input  logic grant,
    output logic winner
);

    localparam int CW = $clog2(MAX_CONSEC + 1);

    logic [CW-1:0] consec;

    assign winner = p1_req && (!p0_req || (consec < CW'(MAX_CONSEC)));

    // Run length only grows while fetch is actually being passed over.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            consec <= '0;
        end else if (grant) begin
            if (winner == PORT_IF || !p0_req) begin
                consec <= '0;
            end else if (consec < CW'(MAX_CONSEC)) begin
                consec <= consec + 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares the AXI-lite bridge port between instruction fetch (port 0) and data access (port 1),
// sequencing issue / wait / respond and timing out hung bus transactions.
module riscv_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_CONSEC  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                p0_req,
    input  logic [ADDR_W-1:0]   p0_addr,
    output logic                p0_ack,
    output logic                p0_err,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wstrb,
    output logic                p1_ack,
    output logic                p1_err,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic                bus_en,
    output logic                bus_write,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_busy,
    output logic                gnt_id,
    output logic                arb_busy,
    output logic                timeout_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WAIT_W = 8;

    arb_state_t          state, state_next;
    logic                sel_grant, sel_winner;
    logic                wait_last;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                lat_gnt, lat_we;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [STRB_W-1:0]   lat_wstrb;
    logic                resp_err, timeout_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;

    assign sel_grant = (state == ST_IDLE) && (p0_req || p1_req);
    assign wait_last = (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1));

    riscv_arb_fair_sel #(.MAX_CONSEC(MAX_CONSEC)) u_fair_sel (
        .clk    (clk),
        .rst_n  (rst_n),
        .p0_req (p0_req),
        .p1_req (p1_req),
        .grant  (sel_grant),
        .winner (sel_winner)
    );

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            ST_IDLE:  if (p0_req || p1_req) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (!bus_busy || wait_last) state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= ST_IDLE;
            lat_gnt   <= PORT_IF;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            wait_cnt  <= '0;
            resp_err  <= 1'b0;
            timeout_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state <= state_next;
            if (sel_grant) begin
                lat_gnt <= sel_winner;
                if (sel_winner == PORT_DATA) begin
                    lat_we    <= p1_we;
                    lat_addr  <= p1_addr;
                    lat_wdata <= p1_wdata;
                    lat_wstrb <= p1_we ? p1_wstrb : '0;
                end else begin
                    lat_we    <= 1'b0;
                    lat_addr  <= p0_addr;
                    lat_wdata <= '0;
                    lat_wstrb <= '0;
                end
            end
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end
            // Completion wins over timeout when both land on the same cycle.
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
                if (!bus_busy) begin
                    resp_err <= 1'b0;
                    if (lat_gnt == PORT_DATA) rdata1_q <= bus_rdata;
                    else                      rdata0_q <= bus_rdata;
                end else if (wait_last) begin
                    resp_err  <= 1'b1;
                    timeout_q <= 1'b1;
                    if (lat_gnt == PORT_DATA) rdata1_q <= '0;
                    else                      rdata0_q <= '0;
                end
            end
        end
    end

    assign bus_en    = (state == ST_ISSUE);
    assign bus_write = lat_we;
    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;
    assign bus_wstrb = lat_wstrb;
    assign gnt_id    = lat_gnt;
    assign arb_busy  = (state != ST_IDLE);
    assign timeout_o = timeout_q;

    assign p0_ack   = (state == ST_RESP) && (lat_gnt == PORT_IF);
    assign p1_ack   = (state == ST_RESP) && (lat_gnt == PORT_DATA);
    assign p0_err   = p0_ack && resp_err;
    assign p1_err   = p1_ack && resp_err;
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Self-checking bench for riscv_mem_arbiter: transaction-timeline model plus directed literal checks.
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_ack, p0_err;
    logic [31:0] p0_addr, p0_rdata;
    logic        p1_req, p1_we, p1_ack, p1_err;
    logic [31:0] p1_addr, p1_wdata, p1_rdata;
    logic [3:0]  p1_wstrb;
    logic        bus_en, bus_write, bus_busy;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    logic        gnt_id, arb_busy, timeout_o;

    always #5 clk = ~clk;

    riscv_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
        .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
        .bus_en(bus_en), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_busy(bus_busy),
        .gnt_id(gnt_id), .arb_busy(arb_busy), .timeout_o(timeout_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bridge responder: busy for cur_delay cycles starting the cycle after bus_en.
    int          cur_delay = 0;
    logic [31:0] cur_rdata = '0;

    initial begin : bridge
        int   remaining;
        logic en_seen;
        remaining = 0;
        bus_busy  = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            en_seen = bus_en;
            @(posedge clk);
            #1;
            if (en_seen) begin
                remaining = cur_delay;
                bus_rdata = cur_rdata;
            end
            bus_busy = (remaining > 0);
            if (remaining > 0) remaining--;
        end
    end

    // Model: each transaction is a timeline (select cycle s, bus_en at s+1, ack at s+2+n).
    typedef struct {
        logic        valid;
        logic        gnt;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          en_c;
        int          ack_c;
        logic        err;
        logic [31:0] rdata;
    } txn_t;

    txn_t        t;
    int          cyc = 0;
    int          next_sel = 0;
    int          consec_m = 0;
    int          force_delay = -1;
    logic [31:0] force_rdata = '0;
    logic        prev_rst_low = 1'b1;
    logic        had_txn = 1'b0;
    logic        exp_to = 1'b0;
    logic [31:0] exp_rd0 = '0, exp_rd1 = '0;

    task automatic model_cycle();
        logic in_win, is_ack, w;
        int   d, n;
        cyc++;
        if (prev_rst_low) begin
            t.valid  = 1'b0;
            exp_rd0  = '0;
            exp_rd1  = '0;
            exp_to   = 1'b0;
            consec_m = 0;
            had_txn  = 1'b0;
            next_sel = cyc;
        end
        in_win = t.valid && cyc >= t.en_c && cyc <= t.ack_c;
        is_ack = t.valid && cyc == t.ack_c;
        if (is_ack) begin
            if (t.gnt) exp_rd1 = t.err ? 32'h0 : t.rdata;
            else       exp_rd0 = t.err ? 32'h0 : t.rdata;
            if (t.err) exp_to = 1'b1;
        end
        check($sformatf("bus_en@%0d", cyc),   bus_en,   t.valid && cyc == t.en_c);
        check($sformatf("arb_busy@%0d", cyc), arb_busy, in_win);
        check($sformatf("p0_ack@%0d", cyc),   p0_ack,   is_ack && !t.gnt);
        check($sformatf("p1_ack@%0d", cyc),   p1_ack,   is_ack && t.gnt);
        check($sformatf("p0_err@%0d", cyc),   p0_err,   is_ack && !t.gnt && t.err);
        check($sformatf("p1_err@%0d", cyc),   p1_err,   is_ack && t.gnt && t.err);
        check($sformatf("p0_rdata@%0d", cyc), p0_rdata, exp_rd0);
        check($sformatf("p1_rdata@%0d", cyc), p1_rdata, exp_rd1);
        check($sformatf("timeout_o@%0d", cyc), timeout_o, exp_to);
        if (in_win) begin
            check($sformatf("gnt_id@%0d", cyc),    gnt_id,    t.gnt);
            check($sformatf("bus_write@%0d", cyc), bus_write, t.we);
            check($sformatf("bus_addr@%0d", cyc),  bus_addr,  t.addr);
            check($sformatf("bus_wstrb@%0d", cyc), bus_wstrb, t.we ? t.wstrb : 4'h0);
            if (t.we) check($sformatf("bus_wdata@%0d", cyc), bus_wdata, t.wdata);
        end else if (!had_txn) begin
            check($sformatf("rst_bus@%0d", cyc),
                  {31'h0, gnt_id} | {31'h0, bus_write} | bus_addr | bus_wdata | {28'h0, bus_wstrb}, 32'h0);
        end
        if (rst_n && cyc == next_sel) begin
            if (p0_req || p1_req) begin
                w = p1_req && (!p0_req || consec_m < 4);
                if (!w || !p0_req) consec_m = 0;
                else if (consec_m < 4) consec_m++;
                t.valid = 1'b1;
                t.gnt   = w;
                t.we    = w ? p1_we : 1'b0;
                t.addr  = w ? p1_addr : p0_addr;
                t.wdata = p1_wdata;
                t.wstrb = p1_wstrb;
                if (force_delay >= 0) begin
                    d       = force_delay;
                    t.rdata = force_rdata;
                end else begin
                    n = $urandom_range(0, 99);
                    d = (n == 0) ? 254 : (n == 1) ? 255 : $urandom_range(0, 4);
                    t.rdata = $urandom();
                end
                n        = (d + 1 > 255) ? 255 : d + 1;
                t.err    = (d >= 255);
                t.en_c   = cyc + 1;
                t.ack_c  = cyc + 2 + n;
                next_sel = t.ack_c + 1;
                had_txn  = 1'b1;
                cur_delay = d;
                cur_rdata = t.rdata;
            end else begin
                next_sel = cyc + 1;
            end
        end
        prev_rst_low = !rst_n;
    endtask

    // Per-cycle snapshot taken mid-cycle, away from the active edge.
    logic        s_en, s_gnt, s_wr, s_busy, s_a0, s_a1, s_e0, s_e1, s_to;
    logic [31:0] s_addr, s_wdata, s_rd0, s_rd1;
    logic [3:0]  s_wstrb;
    int          en_count = 0;
    logic        rnd_on = 1'b0;
    int          rate0 = 0, rate1 = 0;

    task automatic step();
        @(negedge clk);
        model_cycle();
        s_en = bus_en;   s_gnt = gnt_id;  s_wr = bus_write; s_busy = arb_busy;
        s_a0 = p0_ack;   s_a1 = p1_ack;   s_e0 = p0_err;    s_e1 = p1_err;
        s_to = timeout_o; s_addr = bus_addr; s_wdata = bus_wdata; s_wstrb = bus_wstrb;
        s_rd0 = p0_rdata; s_rd1 = p1_rdata;
        if (bus_en) en_count++;
        @(posedge clk);
        #1;
        if (rnd_on) begin
            if (s_a0 || !p0_req) begin
                p0_req  = ($urandom_range(0, 99) < rate0);
                p0_addr = $urandom() & 32'hFFFF_FFFC;
            end
            if (s_a1 || !p1_req) begin
                p1_req   = ($urandom_range(0, 99) < rate1);
                p1_we    = $urandom_range(0, 1);
                p1_addr  = $urandom() & 32'hFFFF_FFFC;
                p1_wdata = $urandom();
                p1_wstrb = $urandom_range(0, 15);
            end
        end
    endtask

    task automatic wait_ack(input logic port, input int bound, output int n, output logic got);
        n = 0;
        got = 1'b0;
        while (!got && n < bound) begin
            step();
            n++;
            got = port ? s_a1 : s_a0;
        end
    endtask

    task automatic wait_en(input int bound, output logic got);
        got = 1'b0;
        for (int i = 0; i < bound && !got; i++) begin
            step();
            got = s_en;
        end
    endtask

    int   exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int   n, gcount;
    logic got, last_gnt;

    initial begin
        rst_n = 1'b0;
        p0_req = 1'b0; p0_addr = '0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h40; p1_wdata = '0; p1_wstrb = '0;
        force_delay = 0; force_rdata = 32'h1111_1111;

        // Reset held with a pending data request.
        step();
        check("rst_en", s_en, 0);
        check("rst_busy", s_busy, 0);
        step();
        check("rst_ack1", s_a1, 0);
        rst_n = 1'b1;
        step();
        check("rel_idle_en", s_en, 0);
        step();
        check("rel_en", s_en, 1);
        check("rel_gnt", s_gnt, 1);
        wait_ack(1'b1, 10, n, got);
        check("rel_ack_seen", got, 1);
        check("min_latency", n, 2);
        check("rel_rdata", s_rd1, 32'h1111_1111);
        p1_req = 1'b0;

        // Single fetch, bridge busy three cycles.
        force_delay = 3; force_rdata = 32'hDEAD_BEEF;
        p0_req = 1'b1; p0_addr = 32'h100; en_count = 0;
        wait_ack(1'b0, 30, n, got);
        check("fetch_ack_seen", got, 1);
        check("fetch_latency", n, 7);
        check("fetch_en_count", en_count, 1);
        check("fetch_write", s_wr, 0);
        check("fetch_rdata", s_rd0, 32'hDEAD_BEEF);
        check("fetch_err", s_e0, 0);
        check("fetch_no_p1_ack", s_a1, 0);
        p0_req = 1'b0;

        // Contention: both held continuously.
        force_delay = 1;
        p0_req = 1'b1; p0_addr = 32'h200;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h300;
        gcount = 0; last_gnt = 1'b0;
        for (int i = 0; i < 400 && gcount < 10; i++) begin
            step();
            if (s_en) begin
                check($sformatf("grant_order[%0d]", gcount), s_gnt, exp_order[gcount]);
                last_gnt = s_gnt;
                gcount++;
            end
        end
        check("grants_seen", gcount, 10);
        wait_ack(last_gnt, 50, n, got);
        check("contention_drain", got, 1);
        p0_req = 1'b0; p1_req = 1'b0;

        // Store: fields stable across the whole transaction window.
        force_delay = 2; force_rdata = 32'hA5A5_A5A5;
        p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h2000_0004; p1_wdata = 32'h1234_5678; p1_wstrb = 4'hF;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (s_busy) begin
                check("store_write", s_wr, 1);
                check("store_addr", s_addr, 32'h2000_0004);
                check("store_wdata", s_wdata, 32'h1234_5678);
                check("store_wstrb", s_wstrb, 4'hF);
                check("store_no_p0_ack", s_a0, 0);
            end
            got = s_a1;
        end
        check("store_ack_seen", got, 1);
        p1_req = 1'b0; p1_we = 1'b0;

        // Hung bridge on a data read.
        force_delay = 300; force_rdata = 32'hCAFE_F00D;
        p1_req = 1'b1; p1_addr = 32'h3000;
        wait_en(10, got);
        check("to_en_seen", got, 1);
        wait_ack(1'b1, 400, n, got);
        check("to_ack_seen", got, 1);
        check("to_latency", n, 256);
        check("to_err", s_e1, 1);
        check("to_rdata", s_rd1, 0);
        check("to_flag", s_to, 1);
        p1_req = 1'b0;
        force_delay = 1; force_rdata = 32'h0BAD_F00D;
        p0_req = 1'b1; p0_addr = 32'h104;
        wait_ack(1'b0, 20, n, got);
        check("post_to_ack_seen", got, 1);
        check("post_to_err", s_e0, 0);
        check("post_to_rdata", s_rd0, 32'h0BAD_F00D);
        check("to_sticky", s_to, 1);
        p0_req = 1'b0;

        // Reset while waiting on the bridge.
        force_delay = 20; force_rdata = 32'h5555_5555;
        p1_req = 1'b1; p1_addr = 32'h5000;
        wait_en(10, got);
        check("mid_en_seen", got, 1);
        step(); step(); step();
        check("mid_in_wait", s_busy, 1);
        rst_n = 1'b0; p1_addr = 32'h6000;
        step();
        check("mid_no_ack", s_a1, 0);
        rst_n = 1'b1; force_delay = 0; force_rdata = 32'h0000_0077;
        step();
        check("mid_rst_idle", s_busy, 0);
        check("mid_rst_to_clear", s_to, 0);
        check("mid_rst_addr", s_addr, 0);
        step();
        check("mid_restart_en", s_en, 1);
        check("mid_fresh_addr", s_addr, 32'h6000);
        wait_ack(1'b1, 10, n, got);
        check("mid_ack_seen", got, 1);
        check("mid_rdata", s_rd1, 32'h0000_0077);
        p1_req = 1'b0;

        // Randomized traffic, including timeout boundary delays.
        force_delay = -1; rate0 = 30; rate1 = 40; rnd_on = 1'b1;
        repeat (4000) step();
        rate0 = 0; rate1 = 0;
        got = 1'b0;
        for (int i = 0; i < 1200 && !got; i++) begin
            step();
            got = !p0_req && !p1_req && !s_busy;
        end
        check("random_drain", got, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, time limit 3000000 expected earlier");
        $fatal(1);
    end

endmodule
